// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the shared memory port.
// Handshake: a requester raises REQx with RWx/ADDRx/WDATAx stable and holds them until ACKx (a one-cycle pulse), then drops REQx.
interface mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          REQ0;
  logic          RW0;
  logic [AW-1:0] ADDR0;
  logic [DW-1:0] WDATA0;
  logic          ACK0;
  logic          REQ1;
  logic          RW1;
  logic [AW-1:0] ADDR1;
  logic [DW-1:0] WDATA1;
  logic          ACK1;
  logic [DW-1:0] RDATA;
  logic [1:0]    OWNER;
  logic [AW-1:0] MA;
  logic [DW-1:0] MDO;
  logic [DW-1:0] MDI;
  logic          MRW;
  logic          MEN;

  modport slave (
    input  REQ0, RW0, ADDR0, WDATA0, REQ1, RW1, ADDR1, WDATA1, MDI,
    output ACK0, ACK1, RDATA, OWNER, MA, MDO, MRW, MEN
  );

  modport master (
    output REQ0, RW0, ADDR0, WDATA0, REQ1, RW1, ADDR1, WDATA1, MDI,
    input  ACK0, ACK1, RDATA, OWNER, MA, MDO, MRW, MEN
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter over one fixed-latency memory (RW=1 load, RW=0 store).
// Define ARB_FIXED_PRIO_EN to make requester 0 always win ties instead of round-robin.
module mem_arbiter #(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int LAT = 1
) (
  input  logic       CK,
  input  logic       RST,
  mem_arbiter_if.slave bus,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          ack0_q, ack1_q;
  logic [1:0]    owner_q;
  logic [AW-1:0] ma_q;
  logic [DW-1:0] mdo_q;
  logic [DW-1:0] rdata_q;
  logic          mrw_q, men_q;
  logic          grant1_d;

`ifdef ARB_FIXED_PRIO_EN
  always_comb grant1_d = !bus.REQ0;
`else
  logic last_q;
  // On a tie the requester that was not served last wins.
  always_comb grant1_d = bus.REQ1 && (!bus.REQ0 || !last_q);
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      owner_q <= 2'b00;
      ma_q    <= '0;
      mdo_q   <= '0;
      rdata_q <= '0;
      mrw_q   <= 1'b1;
      men_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            state_q <= ACCESS;
            men_q   <= 1'b1;
            cnt_q   <= CNT_INIT;
            if (grant1_d) begin
              owner_q <= 2'b10;
              ma_q    <= bus.ADDR1;
              mdo_q   <= bus.WDATA1;
              mrw_q   <= bus.RW1;
            end else begin
              owner_q <= 2'b01;
              ma_q    <= bus.ADDR0;
              mdo_q   <= bus.WDATA0;
              mrw_q   <= bus.RW0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (mrw_q) rdata_q <= bus.MDI;
            men_q   <= 1'b0;
            mrw_q   <= 1'b1;
            state_q <= RESP;
            if (owner_q[1]) ack1_q <= 1'b1;
            else            ack0_q <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= owner_q[1];
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          owner_q <= 2'b00;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ACK0    = ack0_q;
  assign bus.ACK1    = ack1_q;
  assign bus.OWNER   = owner_q;
  assign bus.MA      = ma_q;
  assign bus.MDO     = mdo_q;
  assign bus.MRW     = mrw_q;
  assign bus.MEN     = men_q;
  assign bus.RDATA   = rdata_q;
  assign dbg_state_o = state_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one 16-bit data memory.
- Requester 0 is the CPU load/store port. Requester 1 is a second master, such as a DMA or loader.
- Serialises accesses with a REQ/ACK handshake, round-robin on ties, and a fixed-latency memory model.
- Uses the codebase memory convention: RW=1 load, RW=0 store.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- LAT, 1, memory access cycles per transaction (legal range 1..15).

Ports:
- CK  input  1  clock, all logic on posedge
- RST  input  1  synchronous reset, active-high
- REQ0  input  1  requester 0 request; held until ACK0
- RW0  input  1  requester 0 direction (1 load, 0 store)
- ADDR0  input  AW  requester 0 address
- WDATA0  input  DW  requester 0 store data
- ACK0  output  1  one-cycle completion pulse to requester 0
- REQ1, RW1, ADDR1, WDATA1, ACK1  same as above, for requester 1
- RDATA  output  DW  load data; valid in the cycle ACKx=1
- OWNER  output  2  00 idle, 01 requester 0, 10 requester 1
- MA  output  AW  memory address
- MDO  output  DW  memory write data
- MDI  input  DW  memory read data
- MRW  output  1  memory direction (1 load, 0 store)
- MEN  output  1  memory enable

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are CK and RST.
- Reset values:
  - state=IDLE
  - ACK0=ACK1=0, OWNER=00, MEN=0, MRW=1, MA=0, MDO=0, RDATA=0
  - counter=0, LAST=1, so requester 0 wins the first tie.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Samples REQ0 and REQ1 at each edge.
  - Single request: that requester wins.
  - Both requesting: the requester != LAST wins.
  - On the winning edge, latch the winner's ADDR, WDATA and RW into MA, MDO and MRW.
  - Same edge: set OWNER, MEN=1, counter=LAT-1, go to ACCESS.
  - No request: stay in IDLE, outputs unchanged.
- ACCESS:
  - MEN=1 for exactly LAT cycles; MA, MDO and MRW are held stable.
  - Counter decrements each edge.
  - On the edge where counter==0:
    - Load: RDATA<=MDI. Store: RDATA is unchanged.
    - MEN<=0, MRW<=1, ACK[owner]<=1, LAST<=owner, go to RESP.
- RESP:
  - Exactly one cycle with ACKx=1.
  - Next edge: ACK<=0, OWNER<=00, go to IDLE.
  - RDATA holds its value until the next load completes.
- Latency: a REQ sampled in IDLE at edge k gives MEN=1 in cycles k+1..k+LAT and ACK=1 in cycle k+LAT+1.
  - Minimum REQ-to-REQ turnaround is LAT+2 cycles.
- Handshake rules:
  - A requester holds REQ, RW, ADDR and WDATA stable until it sees ACK.
  - It drops REQ in the cycle after ACK.
  - A REQ still high in IDLE after RESP is a new transaction by definition.
- Requests in ACCESS or RESP are ignored; they wait and are arbitrated in the next IDLE. The loser's REQ is never dropped by the arbiter.
- Fairness: with both REQ permanently high, grants alternate 0,1,0,1...
- Reset during ACCESS or RESP:
  - Transaction aborted; no ACK is issued.
  - MEN=0 from the cycle after the reset edge.
  - LAST returns to 1.
- REQ toggling inside ACCESS has no effect on the in-flight access.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties. LAST is neither updated nor used. Requester 1 is served only when REQ0=0 in IDLE.
- Undefined: round-robin as in Behaviour.

Test Plan:
- Reset, then idle 5 cycles -> OWNER=00, MEN=0, MRW=1, ACK0=ACK1=0, RDATA=0.
- LAT=1, REQ0 store (RW0=0, ADDR0=0x0010, WDATA0=0xBEEF) at edge k -> in cycle k+1, MEN=1, MRW=0, MA=0x0010, MDO=0xBEEF. In cycle k+2, ACK0=1 and OWNER=01. Memory model holds 0xBEEF at 0x0010.
- LAT=3, REQ1 load of 0x0010 (MDI model returns 0xBEEF) -> MEN high 3 cycles, ACK1 pulse in cycle k+4, RDATA=0xBEEF in that cycle and held afterwards.
- REQ0 and REQ1 raised on the same edge after reset, both kept re-requesting -> service order 0,1,0,1. With ARB_FIXED_PRIO_EN defined, the order is 0,0,0 while REQ0 stays high.
- RST asserted in the second ACCESS cycle with LAT=3 -> no ACK pulse. MEN=0 and OWNER=00 from the cycle after. A subsequent tie goes to requester 0.
- REQ1 raised during requester 0's ACCESS -> REQ1 ignored until IDLE, then granted. ACK1 arrives exactly LAT+1 cycles after that IDLE edge.
